cam_mgr: RTL and testbench

CAM_MGR -- requirements
Module: cam_mgr

---
 rtl/cam_mgr.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_cam_mgr.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_mgr.sv
// -----------------------------------------------------------------------------
// cam_mgr
//
// Command front end for an external, combinational CAM. A command is accepted
// in IDLE, searched (or read) in SEARCH, optionally written in WRITE, and
// answered in RESP. A valid bitmap and an occupancy count track which CAM
// entries hold live keys. New keys always go to the lowest free entry.
//
// Optional feature: define CAM_MGR_STATS_EN to add saturating 16-bit LOOKUP
// hit/miss counters (ports hit_cnt, miss_cnt).
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   cmd_valid/ready  command handshake
//   cmd_op           00 LOOKUP, 01 INSERT, 10 DELETE, 11 READ
//   cmd_key          key for LOOKUP/INSERT/DELETE
//   cmd_addr         entry index for READ
//   rsp_valid/ready  response handshake
//   rsp_status       00 OK, 01 NOTFOUND, 10 FULL, 11 EXISTS
//   rsp_addr         entry index associated with the response
//   rsp_key          key associated with the response (stored key for READ)
//   cam_*            CAM request outputs (address, write enable, data, valid)
//   cam_rsp_*        CAM response inputs, combinational from the request
//   occupancy        number of valid entries
//   hit_cnt/miss_cnt LOOKUP statistics (CAM_MGR_STATS_EN only)
// -----------------------------------------------------------------------------
module cam_mgr #(
    parameter int  KEY_WIDTH = 32,
    parameter int  KEY_DEPTH = 16,
    localparam int ADDR_W    = $clog2(KEY_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [KEY_WIDTH-1:0] cmd_key,
    input  logic [ADDR_W-1:0]    cmd_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_status,
    output logic [ADDR_W-1:0]    rsp_addr,
    output logic [KEY_WIDTH-1:0] rsp_key,
    output logic [ADDR_W-1:0]    cam_addr,
    output logic                 cam_addr_vld,
    output logic                 cam_we,
    output logic [KEY_WIDTH-1:0] cam_data,
    output logic                 cam_data_vld,
    input  logic [ADDR_W-1:0]    cam_rsp_addr,
    input  logic                 cam_rsp_hit,
    input  logic [KEY_WIDTH-1:0] cam_rsp_data,
    output logic [ADDR_W:0]      occupancy
`ifdef CAM_MGR_STATS_EN
    ,
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_READ   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_NOTFOUND = 2'b01,
        ST_FULL     = 2'b10,
        ST_EXISTS   = 2'b11
    } status_t;

    localparam logic [ADDR_W:0] DEPTH_OCC = KEY_DEPTH[ADDR_W:0];

    state_t                state;
    state_t                state_next;

    op_t                   op_q;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  hit_q;
    logic [ADDR_W-1:0]     hit_addr_q;

    logic [KEY_DEPTH-1:0]  bitmap;
    logic [ADDR_W-1:0]     free_idx;
    logic                  full;
    logic                  read_in_range;

    assign full          = (occupancy == DEPTH_OCC);
    assign read_in_range = ({1'b0, addr_q} < DEPTH_OCC);

    // Lowest clear bitmap bit; scanning downward lets the lowest index win.
    always_comb begin
        free_idx = '0;
        for (int i = KEY_DEPTH - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                free_idx = ADDR_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and CAM request decode. While rst is high every request and
    // handshake output is forced low so a command caught mid-write never
    // reaches the CAM in the reset cycle.
    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        cam_addr     = '0;
        cam_addr_vld = 1'b0;
        cam_we       = 1'b0;
        cam_data     = '0;
        cam_data_vld = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = SEARCH;
                end
            end

            SEARCH: begin
                state_next = RESP;
                if (op_q == OP_READ) begin
                    cam_addr     = addr_q;
                    cam_addr_vld = 1'b1;
                end else begin
                    cam_data = key_q;
                    if (op_q == OP_INSERT && !cam_rsp_hit && !full) begin
                        state_next = WRITE;
                    end
                    if (op_q == OP_DELETE && cam_rsp_hit) begin
                        state_next = WRITE;
                    end
                end
            end

            WRITE: begin
                // Only a DELETE reaches WRITE with a registered hit.
                cam_addr_vld = 1'b1;
                cam_we       = 1'b1;
                cam_data     = key_q;
                if (hit_q) begin
                    cam_addr     = hit_addr_q;
                    cam_data_vld = 1'b0;
                end else begin
                    cam_addr     = free_idx;
                    cam_data_vld = 1'b1;
                end
                state_next = RESP;
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            cmd_ready    = 1'b0;
            rsp_valid    = 1'b0;
            cam_addr     = '0;
            cam_addr_vld = 1'b0;
            cam_we       = 1'b0;
            cam_data     = '0;
            cam_data_vld = 1'b0;
        end
    end

    // Command capture, search results, bitmap/occupancy bookkeeping and the
    // response registers. Responses are only written on the way into RESP, so
    // they hold steady for as long as the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_LOOKUP;
            key_q      <= '0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            hit_addr_q <= '0;
            bitmap     <= '0;
            occupancy  <= '0;
            rsp_status <= ST_OK;
            rsp_addr   <= '0;
            rsp_key    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= op_t'(cmd_op);
                        key_q  <= cmd_key;
                        addr_q <= cmd_addr;
                    end
                end

                SEARCH: begin
                    hit_q      <= cam_rsp_hit;
                    hit_addr_q <= cam_rsp_addr;
                    rsp_key    <= key_q;
                    rsp_addr   <= '0;
                    case (op_q)
                        OP_READ: begin
                            rsp_key    <= cam_rsp_data;
                            rsp_addr   <= addr_q;
                            rsp_status <= (read_in_range && bitmap[addr_q]) ? ST_OK : ST_NOTFOUND;
                        end
                        OP_LOOKUP: begin
                            if (cam_rsp_hit) begin
                                rsp_status <= ST_OK;
                                rsp_addr   <= cam_rsp_addr;
                            end else begin
                                rsp_status <= ST_NOTFOUND;
                            end
                        end
                        OP_INSERT: begin
                            if (cam_rsp_hit) begin
                                rsp_status <= ST_EXISTS;
                                rsp_addr   <= cam_rsp_addr;
                            end else if (full) begin
                                rsp_status <= ST_FULL;
                            end
                        end
                        OP_DELETE: begin
                            if (!cam_rsp_hit) begin
                                rsp_status <= ST_NOTFOUND;
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                WRITE: begin
                    rsp_status <= ST_OK;
                    if (hit_q) begin
                        // Guarded so occupancy stays equal to the bitmap
                        // popcount even if the CAM reports a stale hit.
                        if (bitmap[hit_addr_q]) begin
                            occupancy <= occupancy - 1'b1;
                        end
                        bitmap[hit_addr_q] <= 1'b0;
                        rsp_addr           <= hit_addr_q;
                    end else begin
                        bitmap[free_idx] <= 1'b1;
                        occupancy        <= occupancy + 1'b1;
                        rsp_addr         <= free_idx;
                    end
                end

                default: begin
                end
            endcase
        end
    end

`ifdef CAM_MGR_STATS_EN
    // LOOKUP outcome counters, updated on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == SEARCH && op_q == OP_LOOKUP) begin
            if (cam_rsp_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else begin
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_mgr.sv
// -----------------------------------------------------------------------------
// tb_cam_mgr
//
// Directed bench for cam_mgr with a behavioural 16x32 CAM attached. Expected
// responses are pushed to a scoreboard queue when a command is accepted and
// popped when the response appears. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cam_mgr;

    localparam int KW = 32;
    localparam int KD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [KW-1:0] cmd_key;
    logic [AW-1:0] cmd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic [KW-1:0] rsp_key;
    logic [AW-1:0] cam_addr;
    logic          cam_addr_vld;
    logic          cam_we;
    logic [KW-1:0] cam_data;
    logic          cam_data_vld;
    logic [AW-1:0] cam_rsp_addr;
    logic          cam_rsp_hit;
    logic [KW-1:0] cam_rsp_data;
    logic [AW:0]   occupancy;
`ifdef CAM_MGR_STATS_EN
    logic [15:0]   hit_cnt;
    logic [15:0]   miss_cnt;
`endif

    localparam logic [1:0] LOOKUP = 2'b00, INSERT = 2'b01, DELETE = 2'b10, READ = 2'b11;
    localparam logic [1:0] OK = 2'b00, NOTFOUND = 2'b01, FULL = 2'b10, EXISTS = 2'b11;

    cam_mgr #(.KEY_WIDTH(KW), .KEY_DEPTH(KD)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_key      (cmd_key),
        .cmd_addr     (cmd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_status   (rsp_status),
        .rsp_addr     (rsp_addr),
        .rsp_key      (rsp_key),
        .cam_addr     (cam_addr),
        .cam_addr_vld (cam_addr_vld),
        .cam_we       (cam_we),
        .cam_data     (cam_data),
        .cam_data_vld (cam_data_vld),
        .cam_rsp_addr (cam_rsp_addr),
        .cam_rsp_hit  (cam_rsp_hit),
        .cam_rsp_data (cam_rsp_data),
        .occupancy    (occupancy)
`ifdef CAM_MGR_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural CAM: combinational search/read, write on the clock edge.
    logic [KW-1:0] cam_mem [KD];
    logic [KD-1:0] cam_vld = '0;

    always_comb begin
        cam_rsp_hit  = 1'b0;
        cam_rsp_addr = '0;
        for (int i = KD - 1; i >= 0; i--) begin
            if (cam_vld[i] && cam_mem[i] == cam_data) begin
                cam_rsp_hit  = 1'b1;
                cam_rsp_addr = AW'(i);
            end
        end
        cam_rsp_data = cam_mem[cam_addr];
    end

    always @(posedge clk) begin
        if (cam_we) begin
            cam_mem[cam_addr] <= cam_data;
            cam_vld[cam_addr] <= cam_data_vld;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    st;
        logic [AW-1:0] addr;
        logic [KW-1:0] key;
        bit            check_key;
        int            lat;
        int            acc;
    } sb_item_t;

    sb_item_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one command, wait for acceptance and push its expected response.
    task automatic applyStimulus(input logic [1:0] op, input logic [KW-1:0] key, input logic [AW-1:0] addr,
                                 input logic [1:0] st, input logic [AW-1:0] eaddr, input logic [KW-1:0] ekey,
                                 input bit check_key, input int lat);
        sb_item_t item;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_addr  = addr;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkValue("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        item.st        = st;
        item.addr      = eaddr;
        item.key       = ekey;
        item.check_key = check_key;
        item.lat       = lat;
        item.acc       = cyc;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the response, compare it with the scoreboard head, optionally
    // stall for hold cycles checking stability, then complete the handshake.
    task automatic checkOutput(input int hold);
        sb_item_t item;
        int n;
        logic [1:0]    st0;
        logic [AW-1:0] ad0;
        logic [KW-1:0] ky0;
        if (sb_q.size() == 0) begin
            checkValue("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        item = sb_q.pop_front();
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkValue("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        checkValue("latency", 32'(cyc - item.acc), 32'(item.lat));
        checkValue("rsp_status", 32'(rsp_status), 32'(item.st));
        checkValue("rsp_addr", 32'(rsp_addr), 32'(item.addr));
        if (item.check_key) checkValue("rsp_key", rsp_key, item.key);
        checkValue("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        st0 = rsp_status;
        ad0 = rsp_addr;
        ky0 = rsp_key;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkValue("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkValue("hold_rsp_status", 32'(rsp_status), 32'(st0));
            checkValue("hold_rsp_addr", 32'(rsp_addr), 32'(ad0));
            checkValue("hold_rsp_key", rsp_key, ky0);
            checkValue("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  stayed_low;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = '0;
        cmd_addr  = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("reset_cam_we", 32'(cam_we), 32'd0);
        checkValue("reset_cam_addr_vld", 32'(cam_addr_vld), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkValue("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkValue("reset_occupancy", 32'(occupancy), 32'd0);
        checkValue("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        checkValue("reset_rsp_status", 32'(rsp_status), 32'd0);
        checkValue("reset_rsp_addr", 32'(rsp_addr), 32'd0);
        checkValue("reset_rsp_key", rsp_key, 32'd0);
        checkValue("reset_cam_data", cam_data, 32'd0);
        checkValue("reset_cam_data_vld", 32'(cam_data_vld), 32'd0);

        // Reset during the WRITE cycle of an INSERT abandons it
        cmd_valid = 1'b1;
        cmd_op    = INSERT;
        cmd_key   = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cam_we && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkValue("write_cycle_seen", 32'(cam_we), 32'd1);
        rst = 1'b1;
        #1;
        checkValue("rst_blocks_cam_we", 32'(cam_we), 32'd0);
        checkValue("rst_blocks_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkValue("post_rst_occupancy", 32'(occupancy), 32'd0);
        checkValue("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        stayed_low = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) stayed_low = 1'b0;
            @(negedge clk);
        end
        checkValue("post_rst_no_rsp", 32'(stayed_low), 32'd1);
        applyStimulus(LOOKUP, 32'hCAFE_F00D, 4'd0, NOTFOUND, 4'd0, 32'h0, 1'b0, 2);
        checkOutput(0);

        // First insert into an empty CAM, then lookups
        applyStimulus(INSERT, 32'hDEAD_BEEF, 4'd0, OK, 4'd0, 32'hDEAD_BEEF, 1'b1, 3);
        checkOutput(0);
        checkValue("occupancy_after_first", 32'(occupancy), 32'd1);
        applyStimulus(LOOKUP, 32'hDEAD_BEEF, 4'd0, OK, 4'd0, 32'hDEAD_BEEF, 1'b1, 2);
        checkOutput(0);
        applyStimulus(LOOKUP, 32'h1234_5678, 4'd0, NOTFOUND, 4'd0, 32'h0, 1'b0, 2);
        checkOutput(0);

        // Fill the remaining 15 entries
        for (int i = 1; i < KD; i++) begin
            applyStimulus(INSERT, 32'h1000_0000 + 32'(i), 4'd0, OK, AW'(i), 32'h1000_0000 + 32'(i), 1'b1, 3);
            checkOutput(0);
        end
        checkValue("occupancy_full", 32'(occupancy), 32'd16);
        applyStimulus(INSERT, 32'hAAAA_0000, 4'd0, FULL, 4'd0, 32'h0, 1'b0, 2);
        checkOutput(0);
        checkValue("occupancy_after_full", 32'(occupancy), 32'd16);
        applyStimulus(INSERT, 32'h1000_0007, 4'd0, EXISTS, 4'd7, 32'h1000_0007, 1'b1, 2);
        checkOutput(0);

        // Delete index 5 and reuse the freed slot
        applyStimulus(DELETE, 32'h1000_0005, 4'd0, OK, 4'd5, 32'h1000_0005, 1'b1, 3);
        checkOutput(0);
        checkValue("occupancy_after_delete", 32'(occupancy), 32'd15);
        applyStimulus(INSERT, 32'hBBBB_0001, 4'd0, OK, 4'd5, 32'hBBBB_0001, 1'b1, 3);
        checkOutput(0);
        checkValue("occupancy_after_reinsert", 32'(occupancy), 32'd16);
        applyStimulus(DELETE, 32'h9999_9999, 4'd0, NOTFOUND, 4'd0, 32'h0, 1'b0, 2);
        checkOutput(0);
        checkValue("occupancy_after_miss_delete", 32'(occupancy), 32'd16);

        // READ with a stalled consumer, then reads/lookups around a delete
        applyStimulus(READ, 32'h0, 4'd3, OK, 4'd3, 32'h1000_0003, 1'b1, 2);
        checkOutput(10);
        applyStimulus(DELETE, 32'h1000_0009, 4'd0, OK, 4'd9, 32'h1000_0009, 1'b1, 3);
        checkOutput(0);
        applyStimulus(READ, 32'h0, 4'd9, NOTFOUND, 4'd9, 32'h0, 1'b0, 2);
        checkOutput(0);
        applyStimulus(LOOKUP, 32'h1000_0009, 4'd0, NOTFOUND, 4'd0, 32'h0, 1'b0, 2);
        checkOutput(0);
        applyStimulus(LOOKUP, 32'hBBBB_0001, 4'd0, OK, 4'd5, 32'hBBBB_0001, 1'b1, 2);
        checkOutput(0);
        checkValue("occupancy_final", 32'(occupancy), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
